// File: rtl/alu_pkg.sv
// Purpose: shared ALU opcode constants, legality check and arbiter FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

   localparam logic [5:0] OP_ADD = 6'b010000;
   localparam logic [5:0] OP_SUB = 6'b010001;
   localparam logic [5:0] OP_SLL = 6'b010010;
   localparam logic [5:0] OP_SRL = 6'b010011;
   localparam logic [5:0] OP_SRA = 6'b010100;
   localparam logic [5:0] OP_EQ  = 6'b100000;
   localparam logic [5:0] OP_NEQ = 6'b100001;
   localparam logic [5:0] OP_LE  = 6'b100010;
   localparam logic [5:0] OP_GT  = 6'b100011;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   function automatic logic is_legal_op(input logic [5:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA,
         OP_EQ, OP_NEQ, OP_LE, OP_GT: return 1'b1;
         default:                     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: round-robin pick among NREQ requesters, searching from last_grant+1.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is taken.
// Ports:
//   req          in   NREQ  request bits
//   last_grant   in   IDW   index granted most recently
//   grant_onehot out  NREQ  winner, one-hot (zero when no request)
//   grant_idx    out  IDW   winner index (0 when no request)
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last_grant,
   output logic [NREQ-1:0] grant_onehot,
   output logic [IDW-1:0]  grant_idx
);

   logic           found;
   logic [IDW-1:0] idx;

   // Walk the ring once, starting just after the previous winner; the
   // first requester seen wins, so no one waits more than NREQ-1 grants.
   always_comb begin
      grant_onehot = '0;
      grant_idx    = '0;
      found        = 1'b0;
      idx          = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = IDW'((int'(last_grant) + k) % NREQ);
         if (!found && req[idx]) begin
            found             = 1'b1;
            grant_onehot[idx] = 1'b1;
            grant_idx         = idx;
         end
      end
   end

endmodule

// File: rtl/alu_req_arbiter.sv
// Purpose: share one ALU among NREQ valid/ready requesters, round-robin, ID-tagged responses.
// Latency: accept to rsp_valid is 3+ALU_LAT cycles (2 cycles for an illegal opcode).
// Backpressure: one op in flight; no request accepted until the response is taken by rsp_ready.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             per-requester handshake (ready one-hot or zero)
//   req_op/req_a/req_b              per-requester payload, slice i = [W*i +: W]
//   alu_op/alu_a/alu_b              registered ALU operands
//   alu_ans1/alu_ans2/alu_z/alu_n   ALU results
//   rsp_valid/rsp_ready             response handshake
//   rsp_id/result/flag/z/n/err      response payload
//   ops_done                        saturating count of delivered responses
module alu_req_arbiter
   import alu_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int IDW     = 2,
   parameter int ALU_LAT = 0,
   parameter int CNTW    = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [6*NREQ-1:0]    req_op,
   input  logic [32*NREQ-1:0]   req_a,
   input  logic [32*NREQ-1:0]   req_b,
   output logic [5:0]           alu_op,
   output logic [31:0]          alu_a,
   output logic [31:0]          alu_b,
   input  logic [31:0]          alu_ans1,
   input  logic                 alu_ans2,
   input  logic                 alu_z,
   input  logic                 alu_n,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [31:0]          rsp_result,
   output logic                 rsp_flag,
   output logic                 rsp_z,
   output logic                 rsp_n,
   output logic                 rsp_err,
   output logic [CNTW-1:0]      ops_done
);

   localparam int CW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

   state_t          state, state_nxt;
   logic [NREQ-1:0] grant_onehot;
   logic [IDW-1:0]  grant_idx;
   logic [IDW-1:0]  last_grant;
   logic [CW-1:0]   cnt;
   logic            accept;
   logic            win_legal;
   logic [5:0]      win_op;
   logic [31:0]     win_a;
   logic [31:0]     win_b;
   logic [5:0]      lat_op;
   logic [31:0]     lat_a;
   logic [31:0]     lat_b;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr (
      .req          (req_valid),
      .last_grant   (last_grant),
      .grant_onehot (grant_onehot),
      .grant_idx    (grant_idx)
   );

   // Payload of the current winner.
   always_comb begin
      win_op = '0;
      win_a  = '0;
      win_b  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_onehot[i]) begin
            win_op = req_op[6*i +: 6];
            win_a  = req_a[32*i +: 32];
            win_b  = req_b[32*i +: 32];
         end
      end
   end

   assign accept    = (state == ST_IDLE) && (|req_valid);
   assign win_legal = is_legal_op(win_op);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      case (state)
         ST_IDLE: begin
            if (|req_valid) begin
               req_ready = grant_onehot;
               state_nxt = win_legal ? ST_ISSUE : ST_RESP;
            end
         end
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT:  if (cnt == '0) state_nxt = ST_RESP;
         ST_RESP:  if (rsp_valid && rsp_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= IDW'(NREQ - 1);
         lat_op     <= '0;
         lat_a      <= '0;
         lat_b      <= '0;
         alu_op     <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         cnt        <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_flag   <= 1'b0;
         rsp_z      <= 1'b0;
         rsp_n      <= 1'b0;
         rsp_err    <= 1'b0;
         ops_done   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  lat_op     <= win_op;
                  lat_a      <= win_a;
                  lat_b      <= win_b;
                  rsp_id     <= grant_idx;
                  last_grant <= grant_idx;
                  rsp_err    <= !win_legal;
                  // An illegal op never reaches the ALU, so its result
                  // fields are zeroed here rather than captured later.
                  if (!win_legal) begin
                     rsp_result <= '0;
                     rsp_flag   <= 1'b0;
                     rsp_z      <= 1'b0;
                     rsp_n      <= 1'b0;
                  end
               end
            end
            ST_ISSUE: begin
               alu_op <= lat_op;
               alu_a  <= lat_a;
               alu_b  <= lat_b;
               cnt    <= CW'(ALU_LAT);
            end
            ST_WAIT: begin
               if (cnt == '0) begin
                  rsp_result <= alu_ans1;
                  rsp_flag   <= alu_ans2;
                  rsp_z      <= alu_z;
                  rsp_n      <= alu_n;
                  rsp_valid  <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_RESP: begin
               // Illegal ops arrive here with rsp_valid still low and
               // raise it one cycle after entry.
               if (!rsp_valid) begin
                  rsp_valid <= 1'b1;
               end else if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if (ops_done != '1) ops_done <= ops_done + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_req_arbiter.sv
module tb_alu_req_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // main instance: ALU_LAT=0, CNTW=4
   logic         rst_n;
   logic [3:0]   req_valid, req_ready;
   logic [23:0]  req_op;
   logic [127:0] req_a, req_b;
   logic [5:0]   alu_op;
   logic [31:0]  alu_a, alu_b, alu_ans1;
   logic         alu_ans2, alu_z, alu_n;
   logic         rsp_valid, rsp_ready, rsp_flag, rsp_z, rsp_n, rsp_err;
   logic [1:0]   rsp_id;
   logic [31:0]  rsp_result;
   logic [3:0]   ops_done;

   // second instance: ALU_LAT=3, CNTW=16
   logic         x_rst_n;
   logic [3:0]   x_req_valid, x_req_ready;
   logic [23:0]  x_req_op;
   logic [127:0] x_req_a, x_req_b;
   logic [5:0]   x_alu_op;
   logic [31:0]  x_alu_a, x_alu_b, x_alu_ans1;
   logic         x_alu_ans2, x_alu_z, x_alu_n;
   logic         x_rsp_valid, x_rsp_flag, x_rsp_z, x_rsp_n, x_rsp_err;
   logic [1:0]   x_rsp_id;
   logic [31:0]  x_rsp_result;
   logic [15:0]  x_ops_done;

   function automatic logic [34:0] alu_model(input logic [5:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [32:0] w;
      logic [31:0] r;
      logic        f;
      w = '0; r = '0; f = 1'b0;
      case (op)
         6'b010000: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; f = w[32]; end
         6'b010001: begin w = {1'b0, a} - {1'b0, b}; r = w[31:0]; f = w[32]; end
         6'b010010: r = a << b[4:0];
         6'b010011: r = a >> b[4:0];
         6'b010100: r = $signed(a) >>> b[4:0];
         6'b100000: begin f = (a == b);                 r = {31'b0, f}; end
         6'b100001: begin f = (a != b);                 r = {31'b0, f}; end
         6'b100010: begin f = ($signed(a) <= $signed(b)); r = {31'b0, f}; end
         6'b100011: begin f = ($signed(a) > $signed(b));  r = {31'b0, f}; end
         default:   r = '0;
      endcase
      return {r, f, (r == 32'd0), r[31]};
   endfunction

   assign {alu_ans1, alu_ans2, alu_z, alu_n}         = alu_model(alu_op, alu_a, alu_b);
   assign {x_alu_ans1, x_alu_ans2, x_alu_z, x_alu_n} = alu_model(x_alu_op, x_alu_a, x_alu_b);

   alu_req_arbiter #(.NREQ(4), .IDW(2), .ALU_LAT(0), .CNTW(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_ans1(alu_ans1), .alu_ans2(alu_ans2), .alu_z(alu_z), .alu_n(alu_n),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_flag(rsp_flag), .rsp_z(rsp_z), .rsp_n(rsp_n),
      .rsp_err(rsp_err), .ops_done(ops_done)
   );

   alu_req_arbiter #(.NREQ(4), .IDW(2), .ALU_LAT(3), .CNTW(16)) dut_lat3 (
      .clk(clk), .rst_n(x_rst_n),
      .req_valid(x_req_valid), .req_ready(x_req_ready),
      .req_op(x_req_op), .req_a(x_req_a), .req_b(x_req_b),
      .alu_op(x_alu_op), .alu_a(x_alu_a), .alu_b(x_alu_b),
      .alu_ans1(x_alu_ans1), .alu_ans2(x_alu_ans2), .alu_z(x_alu_z), .alu_n(x_alu_n),
      .rsp_valid(x_rsp_valid), .rsp_ready(1'b1), .rsp_id(x_rsp_id),
      .rsp_result(x_rsp_result), .rsp_flag(x_rsp_flag), .rsp_z(x_rsp_z), .rsp_n(x_rsp_n),
      .rsp_err(x_rsp_err), .ops_done(x_ops_done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b);
      req_op[6*i +: 6]  = op;
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic wait_rsp(input int maxc);
      int c;
      c = 0;
      while (!rsp_valid && c < maxc) begin
         step();
         c++;
      end
      chk("rsp_timeout", {31'b0, rsp_valid}, 32'd1);
   endtask

   function automatic int oh_idx(input logic [3:0] v);
      int r;
      r = -1;
      for (int i = 0; i < 4; i++) if (v[i]) r = i;
      return r;
   endfunction

   initial begin
      int        nrsp;
      int        cnt_v;
      bit        prev_rdy;
      logic [1:0] exp_ids [4];
      exp_ids = '{2'd0, 2'd2, 2'd0, 2'd2};

      req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
      x_req_valid = '0; x_req_op = '0; x_req_a = '0; x_req_b = '0;
      rst_n = 1'b0; x_rst_n = 1'b0;
      step();
      step();
      // reset state
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_req_ready", {28'b0, req_ready}, 32'd0);
      chk("rst_alu_op", {26'b0, alu_op}, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_result", rsp_result, 32'd0);
      chk("rst_ops_done", {28'b0, ops_done}, 32'd0);
      rst_n = 1'b1; x_rst_n = 1'b1;
      step();

      // 1: single ADD from requester 0
      set_req(0, 6'b010000, 32'h11, 32'h1);
      req_valid = 4'b0001;
      #1 chk("t1_ready", {28'b0, req_ready}, 32'h1);
      step();
      req_valid = '0;
      chk("t1_ready_drop", {28'b0, req_ready}, 32'h0);
      chk("t1_c1_valid", {31'b0, rsp_valid}, 32'd0);
      step();
      chk("t1_c2_valid", {31'b0, rsp_valid}, 32'd0);
      chk("t1_alu_op", {26'b0, alu_op}, 32'h10);
      chk("t1_alu_a", alu_a, 32'h11);
      step();
      chk("t1_c3_valid", {31'b0, rsp_valid}, 32'd1);
      chk("t1_id", {30'b0, rsp_id}, 32'd0);
      chk("t1_result", rsp_result, 32'h12);
      chk("t1_flags", {28'b0, rsp_flag, rsp_z, rsp_n, rsp_err}, 32'd0);
      step();
      chk("t1_valid_clr", {31'b0, rsp_valid}, 32'd0);
      chk("t1_ops_done", {28'b0, ops_done}, 32'd1);

      // 2: requesters 0 and 2 hold valid with SUB
      do_reset();
      set_req(0, 6'b010001, 32'd10, 32'd3);
      set_req(2, 6'b010001, 32'd5, 32'd7);
      req_valid = 4'b0101;
      nrsp = 0; cnt_v = 0; prev_rdy = 1'b0;
      #1;
      for (int cyc = 0; cyc < 60 && nrsp < 4; cyc++) begin
         if (req_ready != 4'b0) begin
            chk("t2_onehot", $countones(req_ready), 32'd1);
            chk("t2_pulse", {31'b0, prev_rdy}, 32'd0);
            if (cnt_v < 4) chk("t2_grant", oh_idx(req_ready), {30'b0, exp_ids[cnt_v]});
            cnt_v++;
         end
         prev_rdy = (req_ready != 4'b0);
         if (rsp_valid) begin
            chk("t2_rsp_id", {30'b0, rsp_id}, {30'b0, exp_ids[nrsp]});
            if (exp_ids[nrsp] == 2'd0) begin
               chk("t2_res0", rsp_result, 32'd7);
               chk("t2_flg0", {30'b0, rsp_flag, rsp_n}, 32'd0);
            end else begin
               chk("t2_res2", rsp_result, 32'hffff_fffe);
               chk("t2_flg2", {30'b0, rsp_flag, rsp_n}, 32'd3);
            end
            nrsp++;
            if (nrsp == 4) req_valid = '0;
         end
         step();
      end
      chk("t2_nrsp", nrsp, 32'd4);
      chk("t2_ngrant", cnt_v, 32'd4);

      // 3: illegal opcode from requester 1
      set_req(1, 6'b111111, 32'h55, 32'h66);
      req_valid = 4'b0010;
      #1 chk("t3_ready", {28'b0, req_ready}, 32'h2);
      step();
      req_valid = '0;
      chk("t3_c1_valid", {31'b0, rsp_valid}, 32'd0);
      step();
      chk("t3_c2_valid", {31'b0, rsp_valid}, 32'd1);
      chk("t3_err", {31'b0, rsp_err}, 32'd1);
      chk("t3_id", {30'b0, rsp_id}, 32'd1);
      chk("t3_result", rsp_result, 32'd0);
      chk("t3_flags", {29'b0, rsp_flag, rsp_z, rsp_n}, 32'd0);
      chk("t3_alu_op", {26'b0, alu_op}, 32'h11);
      step();

      // 4: response backpressure, GT from requester 3, requester 0 waiting
      rsp_ready = 1'b0;
      set_req(3, 6'b100011, 32'hffff_ffff, 32'hffff_fffe);
      req_valid = 4'b1001;
      #1 chk("t4_ready", {28'b0, req_ready}, 32'h8);
      step();
      req_valid = 4'b0001;
      wait_rsp(10);
      for (int k = 0; k < 5; k++) begin
         chk("t4_hold_valid", {31'b0, rsp_valid}, 32'd1);
         chk("t4_hold_id", {30'b0, rsp_id}, 32'd3);
         chk("t4_hold_res", rsp_result, 32'd1);
         chk("t4_hold_flags", {28'b0, rsp_flag, rsp_z, rsp_n, rsp_err}, 32'h8);
         chk("t4_hold_ready", {28'b0, req_ready}, 32'd0);
         step();
      end
      rsp_ready = 1'b1;
      step();
      chk("t4_valid_clr", {31'b0, rsp_valid}, 32'd0);
      chk("t4_ops_done", {28'b0, ops_done}, 32'd6);
      chk("t4_next_grant", {28'b0, req_ready}, 32'h1);
      step();
      req_valid = '0;
      wait_rsp(10);
      chk("t4_next_id", {30'b0, rsp_id}, 32'd0);
      chk("t4_next_res", rsp_result, 32'd7);
      step();
      chk("t4_ops_done2", {28'b0, ops_done}, 32'd7);

      // 6: counter saturation with CNTW=4
      do_reset();
      set_req(0, 6'b010000, 32'd1, 32'd2);
      req_valid = 4'b0001;
      nrsp = 0;
      for (int cyc = 0; cyc < 200 && nrsp < 17; cyc++) begin
         if (rsp_valid) begin
            chk("t6_result", rsp_result, 32'd3);
            chk("t6_ops_done", {28'b0, ops_done}, (nrsp < 15) ? nrsp : 32'd15);
            nrsp++;
            if (nrsp == 17) req_valid = '0;
         end
         step();
      end
      chk("t6_nrsp", nrsp, 32'd17);
      chk("t6_ops_final", {28'b0, ops_done}, 32'hf);

      // 5: ALU_LAT=3 latency, then reset during WAIT
      x_req_op[12 +: 6] = 6'b010000; x_req_a[64 +: 32] = 32'd7; x_req_b[64 +: 32] = 32'd8;
      x_req_valid = 4'b0100;
      #1 chk("t5_ready", {28'b0, x_req_ready}, 32'h4);
      step();
      x_req_valid = '0;
      repeat (4) step();
      chk("t5_c5_valid", {31'b0, x_rsp_valid}, 32'd0);
      step();
      chk("t5_c6_valid", {31'b0, x_rsp_valid}, 32'd1);
      chk("t5_result", x_rsp_result, 32'd15);
      chk("t5_id", {30'b0, x_rsp_id}, 32'd2);
      step();
      chk("t5_ops_done", x_ops_done, 32'd1);
      x_req_op[6 +: 6] = 6'b010001; x_req_a[32 +: 32] = 32'd9; x_req_b[32 +: 32] = 32'd4;
      x_req_valid = 4'b0010;
      #1 chk("t5b_ready", {28'b0, x_req_ready}, 32'h2);
      step();
      x_req_valid = '0;
      step();
      step();
      chk("t5b_alu_a", x_alu_a, 32'd9);
      #2 x_rst_n = 1'b0;
      #1;
      chk("t5_rst_valid", {31'b0, x_rsp_valid}, 32'd0);
      chk("t5_rst_alu_op", {26'b0, x_alu_op}, 32'd0);
      chk("t5_rst_alu_a", x_alu_a, 32'd0);
      chk("t5_rst_ops", x_ops_done, 32'd0);
      #1 x_rst_n = 1'b1;
      cnt_v = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (x_rsp_valid) cnt_v++;
      end
      chk("t5_no_rsp", cnt_v, 32'd0);
      x_req_valid = 4'b0101;
      #1 chk("t5_first_grant", {28'b0, x_req_ready}, 32'h1);
      step();
      x_req_valid = '0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
